// File: rtl/memory_port_unit_if.sv
// Request/response bundle for the memory port: fetch, load and store channels.
// Requests use valid/ready handshakes; responses are valid-only pulses (no backpressure).
// Ports: master drives requests and takes responses; slave is the memory port side.
interface memory_port_unit_if #(
  parameter int XLEN = 32
);
  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [XLEN-1:0]   fetch_addr;
  logic              read_req_valid;
  logic              read_req_ready;
  logic [XLEN-1:0]   read_addr;
  logic              read_reserve;
  logic              write_req_valid;
  logic              write_req_ready;
  logic [XLEN-1:0]   write_addr;
  logic [XLEN-1:0]   write_data;
  logic [XLEN/8-1:0] write_mask;
  logic              write_cond;

  logic              fetch_resp_valid;
  logic [XLEN-1:0]   fetch_resp_data;
  logic              read_resp_valid;
  logic [XLEN-1:0]   read_resp_data;
  logic              write_resp_valid;
  logic              write_resp_sc_fail;
  logic              fetch_exc_valid;
  logic [3:0]        fetch_exc_code;
  logic              read_exc_valid;
  logic [3:0]        read_exc_code;
  logic              write_exc_valid;
  logic [3:0]        write_exc_code;

  modport master (
    output fetch_req_valid, fetch_addr,
    output read_req_valid, read_addr, read_reserve,
    output write_req_valid, write_addr, write_data, write_mask, write_cond,
    input  fetch_req_ready, read_req_ready, write_req_ready,
    input  fetch_resp_valid, fetch_resp_data, read_resp_valid, read_resp_data,
    input  write_resp_valid, write_resp_sc_fail,
    input  fetch_exc_valid, fetch_exc_code, read_exc_valid, read_exc_code,
    input  write_exc_valid, write_exc_code
  );

  modport slave (
    input  fetch_req_valid, fetch_addr,
    input  read_req_valid, read_addr, read_reserve,
    input  write_req_valid, write_addr, write_data, write_mask, write_cond,
    output fetch_req_ready, read_req_ready, write_req_ready,
    output fetch_resp_valid, fetch_resp_data, read_resp_valid, read_resp_data,
    output write_resp_valid, write_resp_sc_fail,
    output fetch_exc_valid, fetch_exc_code, read_exc_valid, read_exc_code,
    output write_exc_valid, write_exc_code
  );
endinterface

// File: rtl/memory_port_unit.sv
// Single-ported word memory arbitrating fetch/load/store with LR/SC reservation and alignment checks.
// Latency: response exactly LATENCY cycles after accept; one accept per cycle, in-order responses.
// Backpressure: at most one ready high per cycle (write > read > fetch, starved fetch promoted); responses never stall.
// Ports: CLK, RESET (sync, active-low), bus (memory_port_unit_if.slave).
module memory_port_unit #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               CLK,
  input logic               RESET,
  memory_port_unit_if.slave bus
);

  localparam int NB  = XLEN / 8;
  localparam int BSH = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam int SW  = $clog2(STARVE_LIMIT + 1) + 1;

  typedef enum logic [1:0] {CH_NONE, CH_FETCH, CH_READ, CH_WRITE} chan_e;

  typedef struct packed {
    logic            vld;
    chan_e           chan;
    logic [XLEN-1:0] dat;
    logic            exc;
    logic [3:0]      code;
    logic            sc_fail;
  } resp_t;

  logic [SW-1:0]   starve_cnt;
  logic            fetch_promoted;
  chan_e           grant;

  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_word;
  logic [AW-1:0]   acc_idx;
  logic            acc_mis;
  logic            acc_oor;
  logic            acc_exc;

  logic            res_vld;
  logic [AW-1:0]   res_idx;
  logic            res_hit;
  logic            do_store;
  logic            sc_fail;
  logic            set_res;
  logic            clr_res;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word;

  resp_t           acc_resp;
  resp_t           pipe [LATENCY];
  resp_t           rsp_out;

  // Arbitration: a fetch that has waited STARVE_LIMIT cycles jumps the queue.
  assign fetch_promoted = (starve_cnt >= SW'(STARVE_LIMIT));

  always_comb begin
    grant = CH_NONE;
    if (RESET) begin
      if (bus.fetch_req_valid && fetch_promoted) grant = CH_FETCH;
      else if (bus.write_req_valid)              grant = CH_WRITE;
      else if (bus.read_req_valid)               grant = CH_READ;
      else if (bus.fetch_req_valid)              grant = CH_FETCH;
    end
  end

  assign bus.fetch_req_ready = (grant == CH_FETCH);
  assign bus.read_req_ready  = (grant == CH_READ);
  assign bus.write_req_ready = (grant == CH_WRITE);

  // Address decode for whichever channel won this cycle.
  always_comb begin
    acc_addr = '0;
    case (grant)
      CH_FETCH: acc_addr = bus.fetch_addr;
      CH_READ:  acc_addr = bus.read_addr;
      CH_WRITE: acc_addr = bus.write_addr;
      default:  acc_addr = '0;
    endcase
  end

  assign acc_word = acc_addr >> BSH;
  assign acc_idx  = acc_word[AW-1:0];
  assign acc_mis  = (acc_addr[BSH-1:0] != '0);
  assign acc_oor  = (acc_word >= XLEN'(DEPTH));
  assign acc_exc  = acc_mis || acc_oor;
  assign res_hit  = res_vld && (res_idx == acc_idx);

  // Store / reservation decisions. Excepting accesses touch nothing.
  always_comb begin
    do_store = 1'b0;
    sc_fail  = 1'b0;
    set_res  = 1'b0;
    clr_res  = 1'b0;
    if (grant == CH_WRITE) begin
      if (acc_exc) begin
        sc_fail = bus.write_cond;
      end else if (bus.write_cond) begin
        do_store = res_hit;
        sc_fail  = !res_hit;
        clr_res  = 1'b1;
      end else begin
        do_store = 1'b1;
        clr_res  = res_hit;
      end
    end
    if (grant == CH_READ && !acc_exc && bus.read_reserve) set_res = 1'b1;
  end

  // Storage is deliberately not reset. Reads sample the array in the accept
  // cycle, so any write accepted earlier is already visible.
  always_ff @(posedge CLK) begin
    if (do_store) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.write_mask[b]) mem[acc_idx][8*b +: 8] <= bus.write_data[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[acc_idx];

  always_comb begin
    acc_resp = '0;
    if (grant != CH_NONE) begin
      acc_resp.vld     = 1'b1;
      acc_resp.chan    = grant;
      acc_resp.exc     = acc_exc;
      acc_resp.sc_fail = sc_fail;
      if (!acc_exc && grant != CH_WRITE) acc_resp.dat = rd_word;
      if (acc_exc) begin
        case (grant)
          CH_FETCH: acc_resp.code = acc_mis ? 4'd0 : 4'd1;
          CH_READ:  acc_resp.code = acc_mis ? 4'd4 : 4'd5;
          CH_WRITE: acc_resp.code = acc_mis ? 4'd6 : 4'd7;
          default:  acc_resp.code = 4'd0;
        endcase
      end
    end
  end

  // Fixed-length delay line; reset drops everything in flight.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= acc_resp;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      starve_cnt <= '0;
      res_vld    <= 1'b0;
      res_idx    <= '0;
    end else begin
      if (bus.fetch_req_valid && grant != CH_FETCH) begin
        if (!fetch_promoted) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
      if (set_res) begin
        res_vld <= 1'b1;
        res_idx <= acc_idx;
      end else if (clr_res) begin
        res_vld <= 1'b0;
      end
    end
  end

  assign rsp_out = pipe[LATENCY-1];

  assign bus.fetch_resp_valid   = rsp_out.vld && (rsp_out.chan == CH_FETCH);
  assign bus.read_resp_valid    = rsp_out.vld && (rsp_out.chan == CH_READ);
  assign bus.write_resp_valid   = rsp_out.vld && (rsp_out.chan == CH_WRITE);
  assign bus.fetch_resp_data    = bus.fetch_resp_valid ? rsp_out.dat : '0;
  assign bus.read_resp_data     = bus.read_resp_valid  ? rsp_out.dat : '0;
  assign bus.write_resp_sc_fail = bus.write_resp_valid && rsp_out.sc_fail;
  assign bus.fetch_exc_valid    = bus.fetch_resp_valid && rsp_out.exc;
  assign bus.read_exc_valid     = bus.read_resp_valid  && rsp_out.exc;
  assign bus.write_exc_valid    = bus.write_resp_valid && rsp_out.exc;
  assign bus.fetch_exc_code     = bus.fetch_exc_valid ? rsp_out.code : 4'd0;
  assign bus.read_exc_code      = bus.read_exc_valid  ? rsp_out.code : 4'd0;
  assign bus.write_exc_code     = bus.write_exc_valid ? rsp_out.code : 4'd0;

endmodule

// File: tb/tb_memory_port_unit.sv
// Bench for memory_port_unit: directed scenarios plus random traffic against a reference model.
// Main instance runs LATENCY=2; a second LATENCY=3 instance covers reset discarding in-flight responses.
// Ports: drives both interface instances; all checks are immediate assertions.
module tb_memory_port_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int SLIM  = 4;
  localparam int VW    = 83;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  memory_port_unit_if #(.XLEN(XLEN)) bus ();
  memory_port_unit_if #(.XLEN(XLEN)) bus3 ();

  memory_port_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .CLK(clk), .RESET(rst_n), .bus(bus)
  );

  memory_port_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(3), .STARVE_LIMIT(SLIM)) dut3 (
    .CLK(clk), .RESET(rst_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mm [DEPTH];
  bit          resv;
  logic [5:0]  resa;
  int          starve;

  typedef struct {
    int            due;
    logic [VW-1:0] vec;
  } pend_t;
  pend_t pend [$];

  // Observed response bundle; data/codes only matter when their valid is up.
  function automatic logic [VW-1:0] obs_vec();
    return {bus.fetch_resp_valid, bus.fetch_resp_valid ? bus.fetch_resp_data : 32'h0,
            bus.fetch_exc_valid, bus.fetch_exc_valid ? bus.fetch_exc_code : 4'h0,
            bus.read_resp_valid, bus.read_resp_valid ? bus.read_resp_data : 32'h0,
            bus.read_exc_valid, bus.read_exc_valid ? bus.read_exc_code : 4'h0,
            bus.write_resp_valid,
            (bus.write_resp_valid && !bus.write_exc_valid) ? bus.write_resp_sc_fail : 1'b0,
            bus.write_exc_valid, bus.write_exc_valid ? bus.write_exc_code : 4'h0};
  endfunction

  // One cycle on the main instance, called at a falling edge.
  task automatic step(input bit r, input bit fv, input logic [31:0] fa,
                      input bit rv, input logic [31:0] ra, input bit rr,
                      input bit wv, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] wm, input bit wc);
    int            g;
    logic [2:0]    exp_rdy;
    logic [2:0]    obs_rdy;
    logic [VW-1:0] expv;
    logic [VW-1:0] obsv;
    logic [VW-1:0] nv;
    logic [31:0]   a;
    logic [31:0]   d;
    logic [3:0]    c;
    logic [5:0]    idx;
    bit            mis, oor, e, sc;
    pend_t         pe;

    rst_n = r;
    bus.fetch_req_valid = fv;  bus.fetch_addr = fa;
    bus.read_req_valid  = rv;  bus.read_addr  = ra;  bus.read_reserve = rr;
    bus.write_req_valid = wv;  bus.write_addr = wa;  bus.write_data   = wd;
    bus.write_mask      = wm;  bus.write_cond = wc;
    #1;

    g = 0;
    if (r) begin
      if (fv && starve >= SLIM) g = 1;
      else if (wv)              g = 3;
      else if (rv)              g = 2;
      else if (fv)              g = 1;
    end
    exp_rdy = {g == 3, g == 2, g == 1};
    obs_rdy = {bus.write_req_ready, bus.read_req_ready, bus.fetch_req_ready};
    checks++;
    assert (obs_rdy === exp_rdy)
      else begin errors++; $error("FAIL ready cyc=%0d observed=%b expected=%b", cyc, obs_rdy, exp_rdy); end

    expv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      pe = pend.pop_front();
      expv = pe.vec;
    end
    obsv = obs_vec();
    checks++;
    assert (obsv === expv)
      else begin errors++; $error("FAIL resp cyc=%0d observed=%h expected=%h", cyc, obsv, expv); end

    if (g != 0) begin
      a   = (g == 1) ? fa : (g == 2) ? ra : wa;
      mis = (a % 4) != 0;
      oor = (a / 4) >= DEPTH;
      e   = mis || oor;
      idx = 6'(a >> 2);
      d   = 32'h0;
      sc  = 1'b0;
      nv  = '0;
      if (g == 1) begin
        c = mis ? 4'd0 : 4'd1;
        if (!e) d = mm[idx];
        nv = {1'b1, d, e, e ? c : 4'h0, 38'h0, 7'h0};
      end else if (g == 2) begin
        c = mis ? 4'd4 : 4'd5;
        if (!e) begin
          d = mm[idx];
          if (rr) begin resv = 1'b1; resa = idx; end
        end
        nv = {38'h0, 1'b1, d, e, e ? c : 4'h0, 7'h0};
      end else begin
        c = mis ? 4'd6 : 4'd7;
        if (!e) begin
          if (wc) begin
            if (resv && resa == idx) begin
              for (int b = 0; b < 4; b++) if (wm[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
              sc = 1'b1;
            end
            resv = 1'b0;
          end else begin
            for (int b = 0; b < 4; b++) if (wm[b]) mm[idx][8*b +: 8] = wd[8*b +: 8];
            if (resv && resa == idx) resv = 1'b0;
          end
        end
        nv = {38'h0, 38'h0, 1'b1, e ? 1'b0 : sc, e, e ? c : 4'h0};
      end
      pe.due = cyc + LAT;
      pe.vec = nv;
      pend.push_back(pe);
    end

    if (!r) begin
      starve = 0;
      resv   = 1'b0;
      pend.delete();
    end else if (fv && g != 1) begin
      starve = (starve < SLIM) ? starve + 1 : SLIM;
    end else begin
      starve = 0;
    end

    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input bit r);
    step(r, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit c);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, a, d, m, c);
  endtask

  task automatic do_r(input logic [31:0] a, input bit res);
    step(1'b1, 1'b0, 32'h0, 1'b1, a, res, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_f(input logic [31:0] a);
    step(1'b1, 1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (k == 1) return 32'(DEPTH * 4 + $urandom_range(0, 63) * 4);
    if (k == 2) return $urandom;
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    starve = 0;
    resv   = 1'b0;
    resa   = '0;
    rst_n  = 1'b0;
    bus.fetch_req_valid = 1'b0; bus.fetch_addr = '0;
    bus.read_req_valid  = 1'b0; bus.read_addr  = '0; bus.read_reserve = 1'b0;
    bus.write_req_valid = 1'b0; bus.write_addr = '0; bus.write_data   = '0;
    bus.write_mask      = '0;   bus.write_cond = 1'b0;
    bus3.fetch_req_valid = 1'b0; bus3.fetch_addr = '0;
    bus3.read_req_valid  = 1'b0; bus3.read_addr  = '0; bus3.read_reserve = 1'b0;
    bus3.write_req_valid = 1'b0; bus3.write_addr = '0; bus3.write_data   = '0;
    bus3.write_mask      = '0;   bus3.write_cond = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, and readies held low under reset even with requests pending
    idle(1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 1'b1, 32'h8, 32'h1, 4'hF, 1'b0);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) do_w(32'(i * 4), $urandom, 4'hF, 1'b0);

    // Write then read same word, read sees new data two cycles after accept
    do_w(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    do_r(32'h10, 1'b0);
    // Partial and empty masks
    do_w(32'h10, 32'h12345678, 4'b0101, 1'b0);
    do_w(32'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
    do_r(32'h10, 1'b0);
    repeat (3) idle(1'b1);

    // All three channels busy: fetch wins on the fifth cycle
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b1, 32'h48, 1'b1, 32'h44, 1'b0, 1'b1, 32'h40, $urandom, 4'hF, 1'b0);
    repeat (3) idle(1'b1);

    // LR then SC succeeds; second SC fails
    do_r(32'h20, 1'b1);
    do_w(32'h20, 32'hA5A5A5A5, 4'hF, 1'b1);
    do_r(32'h20, 1'b0);
    do_w(32'h20, 32'h5A5A5A5A, 4'hF, 1'b1);
    do_r(32'h20, 1'b0);
    // LR, plain write to same word, SC fails
    do_r(32'h20, 1'b1);
    do_w(32'h20, 32'h11112222, 4'hF, 1'b0);
    do_w(32'h20, 32'h33334444, 4'hF, 1'b1);
    do_r(32'h20, 1'b0);
    // SC to a different word than the reservation fails
    do_r(32'h24, 1'b1);
    do_w(32'h28, 32'h77778888, 4'hF, 1'b1);
    repeat (3) idle(1'b1);

    // Exceptions
    do_r(32'h13, 1'b0);
    do_f(32'(DEPTH * 4));
    do_w(32'h2, 32'hCAFEF00D, 4'hF, 1'b0);
    do_r(32'h0, 1'b0);
    do_r(32'(DEPTH * 4 + 1), 1'b0);
    do_w(32'(DEPTH * 4), 32'h1, 4'hF, 1'b0);
    do_f(32'h1);
    do_f(32'h8);
    repeat (3) idle(1'b1);

    // Random traffic with a reset pulse in the middle
    for (int i = 0; i < 400; i++) begin
      step(i != 200,
           $urandom_range(0, 3) != 0, rnd_addr(),
           $urandom_range(0, 1) == 1, rnd_addr(), $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
           ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 3) == 0);
    end
    repeat (4) idle(1'b1);

    // LATENCY=3 instance: response lands exactly three cycles after accept
    bus3.read_req_valid = 1'b1;
    bus3.read_addr      = 32'h0;
    #1;
    checks++;
    assert (bus3.read_req_ready === 1'b1)
      else begin errors++; $error("FAIL lat3_ready observed=%b expected=1", bus3.read_req_ready); end
    @(negedge clk);
    bus3.read_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      assert (bus3.read_resp_valid === (k == 3))
        else begin errors++; $error("FAIL lat3_resp k=%0d observed=%b expected=%b", k, bus3.read_resp_valid, k == 3); end
      @(negedge clk);
    end

    // Reset the cycle after accept: response must never appear
    bus3.read_req_valid = 1'b1;
    #1;
    checks++;
    assert (bus3.read_req_ready === 1'b1)
      else begin errors++; $error("FAIL rst3_ready observed=%b expected=1", bus3.read_req_ready); end
    @(negedge clk);
    bus3.read_req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      rst_n = (k != 1);
      #1;
      checks++;
      assert (bus3.read_resp_valid === 1'b0)
        else begin errors++; $error("FAIL rst3_resp k=%0d observed=%b expected=0", k, bus3.read_resp_valid); end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_port_unit.md
MEMORY_PORT_UNIT -- requirements
Module: memory_port_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 1024, storage size in XLEN-bit words; power of two.
REQ-003 SHALL have parameter LATENCY, default 1, cycles from grant to response; legal range 1..4.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, cycles a fetch may wait before it is promoted.
REQ-005 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have fetch_req_valid/fetch_req_ready, in/out, 1 each, fetch request handshake; fetch_addr, in, XLEN, byte address.
REQ-008 SHALL have read_req_valid/read_req_ready, in/out, 1 each, load request handshake; read_addr, in, XLEN; read_reserve, in, 1, load-reserved.
REQ-009 SHALL have write_req_valid/write_req_ready, in/out, 1 each; write_addr and write_data, in, XLEN each; write_mask, in, XLEN/8, byte enables; write_cond, in, 1, store-conditional.
REQ-010 SHALL have per-channel responses {fetch,read,write}_resp_valid, out, 1; fetch_resp_data and read_resp_data, out, XLEN; write_resp_sc_fail, out, 1.
REQ-011 SHALL have per-channel {fetch,read,write}_exc_valid, out, 1, and {fetch,read,write}_exc_code, out, 4.

Function
REQ-012 SHALL grant at most one request per cycle; a request is accepted when valid and ready are both high in the same cycle.
REQ-013 SHALL use priority write > read > fetch, except that fetch SHALL take highest priority once its starve counter reaches STARVE_LIMIT.
REQ-014 SHALL increment the starve counter in each cycle fetch_req_valid is high and fetch is not granted, saturating at STARVE_LIMIT; it SHALL clear when fetch is granted or fetch_req_valid is low.
REQ-015 SHALL compute ready combinationally from the current valids and the starve counter; ready SHALL be high for the granted channel only.
REQ-016 SHALL assert the granted channel's resp_valid exactly LATENCY cycles after acceptance, for one cycle; responses have no backpressure.
REQ-017 SHALL sustain back-to-back accepts at one per cycle, with responses returned in acceptance order.
REQ-018 SHALL flag an address as misaligned when addr mod (XLEN/8) != 0, and as out of range when addr/(XLEN/8) >= DEPTH.
REQ-019 SHALL report exception codes in the response cycle: fetch misaligned 0, fetch out of range 1, load misaligned 4, load out of range 5, store misaligned 6, store out of range 7; misaligned takes precedence over out of range.
REQ-020 SHALL have no storage or reservation side effects for an excepting access, and its resp_data SHALL be 0.
REQ-021 SHALL write only the bytes with write_mask set on a plain write; a mask of 0 SHALL be accepted with no storage change.
REQ-022 SHALL, on a read with read_reserve=1, set reservation valid and record the word address.
REQ-023 SHALL, on a write with write_cond=1, succeed (store, sc_fail=0) only if the reservation is valid and the word addresses match; otherwise it SHALL not store and SHALL return sc_fail=1.
REQ-024 SHALL clear the reservation after any store-conditional, success or fail.
REQ-025 SHALL clear the reservation on any successful plain write to the reserved word.
REQ-026 SHALL, for a read that follows a write to the same word, return the post-write data whenever the read is accepted on a later cycle than the write.
REQ-027 SHALL drive write_resp_sc_fail as 0 for plain writes.

Reset
REQ-028 SHALL, while RESET=0 at a clock edge, clear all resp_valid, exc_valid, resp data, the starve counter, the reservation and all in-flight pipeline entries; responses in flight at reset are discarded.
REQ-029 SHALL hold all ready outputs low while RESET=0; storage contents are not initialised by reset.

Verification
REQ-030 Scenario: XLEN=32, LATENCY=2; write 0xDEADBEEF to addr 0x10 with mask 0xF, then read 0x10 -> read_resp_valid 2 cycles after the read accept, data 0xDEADBEEF.
REQ-031 Scenario: write, read and fetch valid together every cycle -> fetch granted in the 5th cycle (STARVE_LIMIT=4), then the starve counter is 0.
REQ-032 Scenario: LR at 0x20, then SC at 0x20 -> sc_fail=0 and data stored; a second SC at 0x20 -> sc_fail=1 and no store.
REQ-033 Scenario: LR at 0x20, plain write at 0x20, then SC at 0x20 -> sc_fail=1.
REQ-034 Scenario: read at 0x13 -> exc_code 4; fetch at DEPTH*4 -> exc_code 1; store at 0x2 -> exc_code 6 and memory unchanged.
REQ-035 Scenario: RESET=0 asserted the cycle after a read accept with LATENCY=3 -> no read_resp_valid in any following cycle.
